// File: rtl/cacheline_burst_pkg.sv
// Shared types, default sizes and address helper for the cache-line burst adaptor.
package cacheline_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_CACHE_LINE_WIDTH = 256;
  localparam int DEF_BURST_LEN        = 4;
  localparam int DEF_ADDR_WIDTH       = 32;

  // Clears the byte-offset bits so the address points at the start of a line.
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int offset_bits);
    logic [63:0] mask;
    mask = (64'd1 << offset_bits) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Bridges a full-line cache port to a BURST_LEN-beat memory port: read beats are
// assembled into a line, write lines are split into beats. Single FSM, no
// combinational input-to-output path.
module cacheline_burst_adaptor
  import cacheline_burst_pkg::*;
#(
  parameter int CACHE_LINE_WIDTH = DEF_CACHE_LINE_WIDTH,
  parameter int BURST_LEN        = DEF_BURST_LEN,
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         cache_addr_i,
  input  logic                          cache_read_i,
  input  logic                          cache_write_i,
  input  logic [CACHE_LINE_WIDTH-1:0]   cache_wline_i,
  output logic [CACHE_LINE_WIDTH-1:0]   cache_rline_o,
  output logic                          cache_resp_o,
  output logic                          cache_err_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic                          mem_read_o,
  output logic                          mem_write_o,
  output logic [CACHE_LINE_WIDTH/BURST_LEN-1:0] mem_wdata_o,
  input  logic [CACHE_LINE_WIDTH/BURST_LEN-1:0] mem_rdata_i,
  input  logic                          mem_resp_i,
  input  logic                          mem_error_i
);

  localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;
  localparam int OFFSET_BITS = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int CNT_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic                          err_q, err_d;
  logic [CACHE_LINE_WIDTH-1:0]   rline_q, rline_d;
  logic [CACHE_LINE_WIDTH-1:0]   wline_q, wline_d;
  logic [BURST_WIDTH-1:0]        wbeat;

  // Next-state, beat counter and line-buffer updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    rline_d = rline_q;
    wline_d = wline_q;
    case (state_q)
      IDLE: begin
        // Write wins when both requests are raised together.
        if (cache_write_i) begin
          addr_d  = ADDR_WIDTH'(line_align(64'(cache_addr_i), OFFSET_BITS));
          wline_d = cache_wline_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = WRITE;
        end else if (cache_read_i) begin
          addr_d  = ADDR_WIDTH'(line_align(64'(cache_addr_i), OFFSET_BITS));
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = READ;
        end
      end
      READ: begin
        if (mem_error_i) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (mem_resp_i) begin
          for (int b = 0; b < BURST_LEN; b++) begin
            if (cnt_q == CNT_W'(b)) rline_d[b*BURST_WIDTH +: BURST_WIDTH] = mem_rdata_i;
          end
          // Counter parks on the last beat instead of wrapping.
          if (cnt_q == LAST_BEAT) state_d = DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (mem_error_i) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (mem_resp_i) begin
          if (cnt_q == LAST_BEAT) state_d = DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select the write beat addressed by the counter.
  always_comb begin
    wbeat = '0;
    for (int b = 0; b < BURST_LEN; b++) begin
      if (cnt_q == CNT_W'(b)) wbeat = wline_q[b*BURST_WIDTH +: BURST_WIDTH];
    end
  end

  // Control state and cache-visible registers; reset discards partial beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      rline_q <= rline_d;
    end
  end

  // Write-line holding buffer; only observed through the gated beat mux.
  always_ff @(posedge clk) begin
    wline_q <= wline_d;
  end

  assign mem_read_o    = (state_q == READ);
  assign mem_write_o   = (state_q == WRITE);
  assign mem_wdata_o   = mem_write_o ? wbeat : '0;
  assign mem_addr_o    = addr_q;
  assign cache_resp_o  = (state_q == DONE);
  assign cache_err_o   = (state_q == DONE) && err_q;
  assign cache_rline_o = rline_q;

endmodule
